// File: rtl/line_buffer3.sv
// Three-row line buffer: stores rows r-2 and r-1 so a 3x3 window stage sees one full pixel column per cycle.
// Latency: one clock from an accepted pixel to the registered column on pix_top/pix_mid/pix_bot.
// Backpressure: none; every valid input pixel is taken, and the consumer must take every out_valid cycle.
//
// Ports:
//   clk              single clock; all state changes on the rising edge
//   rst              synchronous active-high reset (line memories are not cleared)
//   in_valid         in_pixel carries a raster-order pixel this cycle
//   in_sof           start of frame, qualified by in_valid; the pixel is row 0, column 0
//   in_pixel         incoming pixel, PIXEL_WIDTH bits, passed bit-exact
//   out_valid        pix_top/pix_mid/pix_bot hold one valid column this cycle
//   pix_top          column pixel from row r-2
//   pix_mid          column pixel from row r-1
//   pix_bot          column pixel from row r (the current input row)
//   out_eol          qualified by out_valid; the column is LINE_WIDTH-1
module line_buffer3 #(
  parameter int PIXEL_WIDTH = 8,
  parameter int LINE_WIDTH  = 640
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  input  logic                   in_sof,
  input  logic [PIXEL_WIDTH-1:0] in_pixel,
  output logic                   out_valid,
  output logic [PIXEL_WIDTH-1:0] pix_top,
  output logic [PIXEL_WIDTH-1:0] pix_mid,
  output logic [PIXEL_WIDTH-1:0] pix_bot,
  output logic                   out_eol
);

  localparam int COL_W = (LINE_WIDTH > 1) ? $clog2(LINE_WIDTH) : 1;
  localparam logic [COL_W-1:0] COL_LAST  = COL_W'(LINE_WIDTH - 1);
  localparam logic [COL_W-1:0] COL_FIRST = '0;
  localparam logic [COL_W-1:0] COL_ONE   = COL_W'(1);

  // WAIT_SOF: no frame yet; FILL0/FILL1: rows 0 and 1 being stored; STREAM: row 2 onwards.
  typedef enum logic [1:0] {
    WAIT_SOF = 2'd0,
    FILL0    = 2'd1,
    FILL1    = 2'd2,
    STREAM   = 2'd3
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [COL_W-1:0] col;
  logic [COL_W-1:0] col_nxt;

  // line_a holds row r-2, line_b holds row r-1, both indexed by column.
  logic [PIXEL_WIDTH-1:0] line_a [LINE_WIDTH];
  logic [PIXEL_WIDTH-1:0] line_b [LINE_WIDTH];

  logic             accept;   // pixel is written into the line memories
  logic             emit;     // pixel produces an output column next cycle
  logic             wrap;     // accepted non-sof pixel is the last column of its row
  logic [COL_W-1:0] wr_col;   // column the accepted pixel belongs to

  // ---------------------------------------------------------------------------
  // Decode of the current input against the frame state.
  // ---------------------------------------------------------------------------
  always_comb begin
    accept = 1'b0;
    emit   = 1'b0;
    wrap   = 1'b0;
    wr_col = col;

    if (in_valid) begin
      if (in_sof) begin
        // A start of frame always restarts at column 0, wherever the old line was.
        accept = 1'b1;
        wr_col = COL_FIRST;
      end else if (state != WAIT_SOF) begin
        accept = 1'b1;
        wrap   = (col == COL_LAST);
        emit   = (state == STREAM);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: state register.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= WAIT_SOF;
      col   <= COL_FIRST;
    end else begin
      state <= state_nxt;
      col   <= col_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state and column counter.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    col_nxt   = col;

    if (in_valid && in_sof) begin
      // The sof pixel itself occupies column 0, so the next pixel is column 1.
      state_nxt = FILL0;
      col_nxt   = COL_ONE;
    end else if (accept) begin
      if (wrap) begin
        col_nxt = COL_FIRST;
        case (state)
          FILL0:   state_nxt = FILL1;
          FILL1:   state_nxt = STREAM;
          STREAM:  state_nxt = STREAM;
          default: state_nxt = state;
        endcase
      end else begin
        col_nxt = col + COL_ONE;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Line memories: shift the column down one row per accepted pixel.
  // No reset here; rows 0 and 1 of every frame rewrite every column before
  // anything is read out, so stale contents never reach the outputs.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst && accept) begin
      line_a[wr_col] <= line_b[wr_col];
      line_b[wr_col] <= in_pixel;
    end
  end

  // ---------------------------------------------------------------------------
  // Output column register. The memory reads see the values from before this
  // edge's write, which is exactly rows r-2 and r-1 for this column.
  // Pixel outputs hold between valid columns.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_eol   <= 1'b0;
      pix_top   <= '0;
      pix_mid   <= '0;
      pix_bot   <= '0;
    end else begin
      out_valid <= emit;
      out_eol   <= emit && (col == COL_LAST);
      if (emit) begin
        pix_top <= line_a[col];
        pix_mid <= line_b[col];
        pix_bot <= in_pixel;
      end
    end
  end

endmodule

// File: tb/tb_line_buffer3.sv
// Testbench for line_buffer3 (LINE_WIDTH=4, PIXEL_WIDTH=8): directed frames plus random traffic,
// every cycle compared against a row/column reference model of the image.
// Clock period 10; inputs driven 1 time unit after the rising edge, outputs sampled at the same point.
module tb_line_buffer3;

  localparam int PW = 8;
  localparam int LW = 4;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic          in_sof;
  logic [PW-1:0] in_pixel;
  logic          out_valid;
  logic [PW-1:0] pix_top;
  logic [PW-1:0] pix_mid;
  logic [PW-1:0] pix_bot;
  logic          out_eol;

  line_buffer3 #(.PIXEL_WIDTH(PW), .LINE_WIDTH(LW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_sof    (in_sof),
    .in_pixel  (in_pixel),
    .out_valid (out_valid),
    .pix_top   (pix_top),
    .pix_mid   (pix_mid),
    .pix_bot   (pix_bot),
    .out_eol   (out_eol)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int out_cnt  = 0;

  // Reference model: the image is tracked by row and column; the last three
  // rows live in rowbuf indexed by row modulo 3.
  logic [PW-1:0] rowbuf [3][LW];
  bit            active = 1'b0;
  int            row    = 0;
  int            colm   = 0;
  logic          exp_valid = 1'b0;
  logic          exp_eol   = 1'b0;
  logic [PW-1:0] exp_top   = '0;
  logic [PW-1:0] exp_mid   = '0;
  logic [PW-1:0] exp_bot   = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
  endtask

  task automatic model(input logic v, input logic s, input logic [PW-1:0] px, input logic r);
    exp_valid = 1'b0;
    exp_eol   = 1'b0;
    if (r) begin
      active  = 1'b0;
      exp_top = '0;
      exp_mid = '0;
      exp_bot = '0;
    end else if (v && s) begin
      active       = 1'b1;
      row          = 0;
      rowbuf[0][0] = px;
      colm         = 1;
    end else if (v && active) begin
      if (row >= 2) begin
        exp_valid = 1'b1;
        exp_top   = rowbuf[(row - 2) % 3][colm];
        exp_mid   = rowbuf[(row - 1) % 3][colm];
        exp_bot   = px;
        exp_eol   = (colm == LW - 1);
      end
      rowbuf[row % 3][colm] = px;
      colm++;
      if (colm == LW) begin
        colm = 0;
        row++;
      end
    end
  endtask

  task automatic step(input logic v, input logic s, input logic [PW-1:0] px, input logic r);
    in_valid = v;
    in_sof   = s;
    in_pixel = px;
    rst      = r;
    model(v, s, px, r);
    @(posedge clk);
    #1;
    if (out_valid === 1'b1) out_cnt++;
    check("out_valid", {31'd0, out_valid}, {31'd0, exp_valid});
    check("out_eol",   {31'd0, out_eol},   {31'd0, exp_eol});
    check("pix_top",   {24'd0, pix_top},   {24'd0, exp_top});
    check("pix_mid",   {24'd0, pix_mid},   {24'd0, exp_mid});
    check("pix_bot",   {24'd0, pix_bot},   {24'd0, exp_bot});
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 8'($urandom), 1'b0);
  endtask

  // Frame of 16 pixels, value 4*row+col plus a base; optional idle cycle after each pixel.
  task automatic send_frame(input logic [PW-1:0] base, input bit gaps);
    for (int p = 0; p < 16; p++) begin
      step(1'b1, p == 0, base + 8'(p), 1'b0);
      if (gaps) idle();
    end
  endtask

  initial begin
    in_valid = 1'b0;
    in_sof   = 1'b0;
    in_pixel = '0;
    rst      = 1'b1;
    #1;

    // Reset state.
    step(1'b0, 1'b0, 8'h00, 1'b1);
    step(1'b0, 1'b0, 8'h00, 1'b1);
    idle();

    // Continuous reference frame 0x00..0x0F: rows 2 and 3 give 8 columns.
    out_cnt = 0;
    send_frame(8'h00, 1'b0);
    idle();
    check("frame_out_cnt", 32'(out_cnt), 32'd8);

    // Same frame with idle cycles interleaved.
    out_cnt = 0;
    send_frame(8'h00, 1'b1);
    check("gap_frame_out_cnt", 32'(out_cnt), 32'd8);

    // Pixels before any sof after reset are dropped.
    step(1'b0, 1'b0, 8'h00, 1'b1);
    out_cnt = 0;
    for (int i = 0; i < 12; i++) step(1'b1, 1'b0, 8'($urandom), 1'b0);
    check("pre_sof_out_cnt", 32'(out_cnt), 32'd0);
    send_frame(8'h00, 1'b0);

    // sof reasserted at row 2, column 2 restarts the frame with fresh data.
    for (int p = 0; p < 10; p++) step(1'b1, p == 0, 8'h20 + 8'(p), 1'b0);
    out_cnt = 0;
    for (int p = 0; p < 8; p++) step(1'b1, p == 0, 8'h40 + 8'(p), 1'b0);
    check("restart_out_cnt", 32'(out_cnt), 32'd0);
    for (int p = 8; p < 16; p++) step(1'b1, 1'b0, 8'h40 + 8'(p), 1'b0);

    // Reset during row 3, then pixels without sof are dropped.
    for (int p = 0; p < 14; p++) step(1'b1, p == 0, 8'h60 + 8'(p), 1'b0);
    step(1'b1, 1'b0, 8'h6E, 1'b1);
    out_cnt = 0;
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 8'($urandom), 1'b0);
    check("post_rst_out_cnt", 32'(out_cnt), 32'd0);

    // Extreme values are passed bit-exact.
    for (int p = 0; p < 16; p++) step(1'b1, p == 0, (p % 2 == 0) ? 8'h80 : 8'hFF, 1'b0);

    // Random traffic: gaps, extreme values, occasional sof and reset.
    step(1'b1, 1'b1, 8'($urandom), 1'b0);
    for (int i = 0; i < 1500; i++) begin
      logic          r, v, s;
      logic [PW-1:0] px;
      int            sel;
      r   = ($urandom % 250) == 0;
      v   = ($urandom % 4) != 0;
      s   = v && (($urandom % 60) == 0);
      sel = int'($urandom % 4);
      px  = (sel == 0) ? 8'h80 : (sel == 1) ? 8'hFF : 8'($urandom);
      if (!active && !r && v && ($urandom % 8) == 0) s = 1'b1;
      step(v, s, px, r);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/line_buffer3.md
LINE_BUFFER3 -- requirements
Module: line_buffer3

Interface
REQ-001 The block SHALL have parameter PIXEL_WIDTH, default 8, bits per pixel.
REQ-002 The block SHALL have parameter LINE_WIDTH, default 640, pixels per image line, minimum 2.
REQ-003 The block SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst  input  1  reset; one clock, synchronous, active-high.
REQ-005 The block SHALL have port in_valid  input  1  in_pixel carries a raster-order pixel this cycle.
REQ-006 The block SHALL have port in_sof  input  1  start of frame; qualified by in_valid; marks row 0, column 0.
REQ-007 The block SHALL have port in_pixel  input  PIXEL_WIDTH  incoming pixel, passed bit-exact (no sign interpretation).
REQ-008 The block SHALL have port out_valid  output  1  pix_top/pix_mid/pix_bot hold one valid column this cycle.
REQ-009 The block SHALL have ports pix_top, pix_mid, pix_bot  output  PIXEL_WIDTH each  same column from rows r-2, r-1, r; these feed the 3x3 convolution stage directly.
REQ-010 The block SHALL have port out_eol  output  1  qualified by out_valid; column LINE_WIDTH-1.

Function
REQ-011 The block SHALL store two lines, line_a (row r-2) and line_b (row r-1), each LINE_WIDTH x PIXEL_WIDTH, addressed by column counter col.
REQ-012 The FSM SHALL have states WAIT_SOF, FILL0, FILL1, STREAM.
REQ-013 When in_valid=0, col, state, memories and outputs other than out_valid/out_eol SHALL hold; out_valid and out_eol SHALL be 0.
REQ-014 When in_valid=1 and in_sof=1, in any state, the pixel SHALL be taken as row 0, column 0: it is written to line_b[0], col becomes 1, state becomes FILL0.
REQ-015 In WAIT_SOF, in_valid=1 with in_sof=0 SHALL be dropped with no state or memory change.
REQ-016 Every accepted pixel SHALL perform line_a[col] <= line_b[col] and line_b[col] <= in_pixel in the same cycle.
REQ-017 col SHALL increment per accepted pixel and wrap from LINE_WIDTH-1 to 0; on wrap, FILL0->FILL1, FILL1->STREAM, STREAM->STREAM.
REQ-018 In STREAM, an accepted pixel at column c SHALL produce, on the next clock: out_valid=1, pix_top = old line_a[c], pix_mid = old line_b[c] (values read before the REQ-016 write), pix_bot = in_pixel, out_eol = (c == LINE_WIDTH-1).
REQ-019 Latency SHALL be exactly one clock from the accepted input to the registered output; throughput SHALL be one pixel per clock with no stalls.
REQ-020 In FILL0/FILL1, out_valid SHALL be 0; no output is produced for rows 0 and 1.
REQ-021 in_sof at a column other than 0, i.e. mid-line, SHALL abandon the partial line and restart per REQ-014; stale memory contents SHALL be overwritten before use, because output begins only at row 2.
REQ-022 There SHALL be no backpressure; the downstream stage consumes every out_valid cycle.

Reset
REQ-023 While rst=1 at a clock edge: state <= WAIT_SOF, col <= 0, out_valid <= 0, out_eol <= 0, pix_top/pix_mid/pix_bot <= 0; in_valid is ignored that cycle.
REQ-024 Line memories SHALL NOT be reset; their contents are never output before being rewritten (REQ-020).
REQ-025 Reset asserted mid-line or mid-frame SHALL take effect on that edge; output resumes only after a new in_sof plus two full lines.

Verification (LINE_WIDTH=4, PIXEL_WIDTH=8)
REQ-026 Reset, then a frame of pixels 0x00..0x0F (value = 4*row+col) continuous from in_sof -> out_valid first high one clock after pixel 0x08; columns 0..3 give (top,mid,bot) = (00,04,08),(01,05,09),(02,06,0A),(03,07,0B); out_eol only on the fourth; row 3 gives (04,08,0C)..(07,0B,0F).
REQ-027 Same frame with in_valid=0 inserted every other cycle -> identical output sequence; out_valid is never high in a cycle that does not follow an accepted pixel.
REQ-028 Pixels sent before any in_sof after reset -> out_valid stays 0; a later in_sof frame behaves exactly as REQ-026.
REQ-029 in_sof reasserted at row 2, column 2 -> out_valid 0 for the next 8 accepted pixels; output restarts at the new row 2 with fresh data only.
REQ-030 rst pulsed for one cycle during row 3 -> all outputs 0 next cycle; following pixels without in_sof are dropped.
REQ-031 Pixel values 0x80 and 0xFF -> passed bit-exact on pix_top/pix_mid/pix_bot.
